dcache_nway: RTL

- Parametrised successor to the 2-way data cache: N-way set-associative, write-back, write-allocate.
- Configurable set count and words per block; true-LRU replacement; multi-word burst writeback and fill.
- Sits between the datapath data port and the memory/cache controller.
- On halt: flushes every dirty block, optionally writes a hit count to memory, then asserts flushed.

---
 rtl/dcache_nway.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - N-way set-associative write-back, write-allocate data cache
//
// Purpose: sits between the datapath data port and the memory controller.
//   True-LRU replacement, multi-word burst writeback and fill, flush on halt.
//   Optional feature macro: DCACHE_HITCNT_EN (hit counter written to HITCNT_ADDR
//   after the flush completes).
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   dmemREN/dmemWEN/dmemaddr/dmemstore/halt   datapath request side
//   dmemload/dhit/flushed         datapath response side
//   dREN/dWEN/daddr/dstore        memory request side
//   dload/dwait                   memory response side
module dcache_nway #(
    parameter int          WAYS        = 2,
    parameter int          SETS        = 8,
    parameter int          WORDS       = 2,
    parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic [31:0] dmemload,
    output logic        dhit,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int OFFB = $clog2(WORDS);
    localparam int IDXB = $clog2(SETS);
    localparam int TAGB = 30 - OFFB - IDXB;
    localparam int WAYB = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNTB = (WORDS > 1) ? OFFB : 1;
    localparam logic [WAYB-1:0] AGE_MAX  = WAYB'(WAYS - 1);
    localparam logic [WAYB-1:0] WAY_LAST = WAYB'(WAYS - 1);
    localparam logic [CNTB-1:0] CNT_LAST = CNTB'(WORDS - 1);
    localparam logic [IDXB-1:0] SET_LAST = IDXB'(SETS - 1);

    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNTWR, DONE} state_t;

    logic [TAGB-1:0] tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][WORDS];
    logic            valid_q [SETS][WAYS];
    logic            dirty_q [SETS][WAYS];
    logic [WAYB-1:0] age_q   [SETS][WAYS];

    state_t          state;
    logic [CNTB-1:0] cnt;
    logic [WAYB-1:0] vic_q;
    logic [WAYB-1:0] fw;
    logic [IDXB-1:0] fs;
`ifdef DCACHE_HITCNT_EN
    logic [31:0]     hitcnt;
`endif

    logic [TAGB-1:0] req_tag;
    logic [IDXB-1:0] req_idx;
    logic [CNTB-1:0] req_off;
    logic            req;
    logic            unused_ok;

    assign req_tag = dmemaddr[31 -: TAGB];
    assign req_idx = dmemaddr[2+OFFB +: IDXB];
    assign req     = dmemREN | dmemWEN;

    generate
        if (WORDS > 1) begin : g_off
            assign req_off = dmemaddr[2 +: CNTB];
        end else begin : g_nooff
            assign req_off = '0;
        end
    endgenerate

`ifdef DCACHE_HITCNT_EN
    assign unused_ok = ^dmemaddr[1:0];
`else
    assign unused_ok = ^{dmemaddr[1:0], HITCNT_ADDR};
`endif

    function automatic logic [31:0] blk_addr(input logic [TAGB-1:0] t,
                                             input logic [IDXB-1:0] i,
                                             input logic [CNTB-1:0] c);
        return {t, i, {(OFFB+2){1'b0}}} | (32'(c) << 2);
    endfunction

    logic            hit;
    logic [WAYB-1:0] hit_way;
    logic [WAYB-1:0] victim;
    logic [WAYB-1:0] vic_age;
    logic [WAYB-1:0] vic_inv;
    logic            inv_found;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vic_age   = '0;
        vic_inv   = '0;
        inv_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAYB'(w);
            end
        end
        // Descending scans so the lowest matching index wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (age_q[req_idx][w] == AGE_MAX) vic_age = WAYB'(w);
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                vic_inv   = WAYB'(w);
            end
        end
        victim = inv_found ? vic_inv : vic_age;
    end

    logic idle_hit, flush_dirty, flush_step, fill_xfer;
    assign idle_hit    = (state == IDLE) && !halt && req && hit;
    assign flush_dirty = valid_q[fs][fw] && dirty_q[fs][fw];
    assign flush_step  = (state == FLUSH) && (!flush_dirty || (!dwait && cnt == CNT_LAST));
    assign fill_xfer   = (state == FILL) && !dwait;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            vic_q <= '0;
            fs    <= '0;
            fw    <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
`ifdef DCACHE_HITCNT_EN
            hitcnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= FLUSH;
                        cnt   <= '0;
                        fs    <= '0;
                        fw    <= '0;
                    end else if (req) begin
                        if (hit) begin
                            for (int w = 0; w < WAYS; w++) begin
                                if (WAYB'(w) == hit_way)
                                    age_q[req_idx][w] <= '0;
                                else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                                    age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                            end
                            if (dmemWEN) dirty_q[req_idx][hit_way] <= 1'b1;
`ifdef DCACHE_HITCNT_EN
                            hitcnt <= hitcnt + 32'd1;
`endif
                        end else begin
                            vic_q <= victim;
                            cnt   <= '0;
                            state <= (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? WB : FILL;
                        end
                    end
                end
                WB: begin
                    if (!dwait) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= FILL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (!dwait) begin
                        if (cnt == CNT_LAST) begin
                            cnt                     <= '0;
                            valid_q[req_idx][vic_q] <= 1'b1;
                            dirty_q[req_idx][vic_q] <= 1'b0;
                            // Enter as oldest so the hit that follows in IDLE ages
                            // every other way; keeps the ages a permutation.
                            age_q[req_idx][vic_q]   <= AGE_MAX;
                            state                   <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_dirty && !dwait) begin
                        if (cnt == CNT_LAST) begin
                            cnt             <= '0;
                            dirty_q[fs][fw] <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    if (flush_step) begin
                        if (fw == WAY_LAST) begin
                            fw <= '0;
                            if (fs == SET_LAST) begin
                                for (int s = 0; s < SETS; s++)
                                    for (int w = 0; w < WAYS; w++)
                                        valid_q[s][w] <= 1'b0;
`ifdef DCACHE_HITCNT_EN
                                state <= CNTWR;
`else
                                state <= DONE;
`endif
                            end else begin
                                fs <= fs + 1'b1;
                            end
                        end else begin
                            fw <= fw + 1'b1;
                        end
                    end
                end
                CNTWR: if (!dwait) state <= DONE;
                DONE:  state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays need no reset; valid bits qualify them.
    always_ff @(posedge CLK) begin
        if (idle_hit && dmemWEN) data_q[req_idx][hit_way][req_off] <= dmemstore;
        if (fill_xfer) data_q[req_idx][vic_q][cnt] <= dload;
        if (fill_xfer && cnt == CNT_LAST) tag_q[req_idx][vic_q] <= req_tag;
    end

    // Outputs decode the registered state; RST forces them low immediately.
    always_comb begin
        dmemload = '0;
        dhit     = 1'b0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (!req) begin
                        dhit = 1'b1;
                    end else if (hit && !halt) begin
                        dhit = 1'b1;
                        if (!dmemWEN) dmemload = data_q[req_idx][hit_way][req_off];
                    end
                end
                WB: begin
                    dWEN   = 1'b1;
                    daddr  = blk_addr(tag_q[req_idx][vic_q], req_idx, cnt);
                    dstore = data_q[req_idx][vic_q][cnt];
                end
                FILL: begin
                    dREN  = 1'b1;
                    daddr = blk_addr(req_tag, req_idx, cnt);
                end
                FLUSH: begin
                    if (flush_dirty) begin
                        dWEN   = 1'b1;
                        daddr  = blk_addr(tag_q[fs][fw], fs, cnt);
                        dstore = data_q[fs][fw][cnt];
                    end
                end
`ifdef DCACHE_HITCNT_EN
                CNTWR: begin
                    dWEN   = 1'b1;
                    daddr  = HITCNT_ADDR;
                    dstore = hitcnt;
                end
`endif
                DONE: begin
                    flushed = 1'b1;
                    dhit    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
